// File: rtl/counter_pkg.sv
// Shared constants and helpers for modulo-N counter cells and their instantiators.
// No logic; elaboration-time only.
// No flow control.
package counter_pkg;

    // Common moduli for digit cells: decimal digit, hex nibble, seconds/minutes.
    localparam int DEC_MOD = 10;
    localparam int HEX_MOD = 16;
    localparam int SEC_MOD = 60;

    // Ceiling log2, used by instantiators to size WIDTH from a modulus.
    // Returns at least 1 so a modulus of 1 or 2 still gets a 1-bit counter.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter cell with parallel load, cascade terminal count and wrap pulse.
// Latency: q and wrap update one clock after the qualifying edge; tc is combinational.
// Backpressure: none; en is the only qualifier and cascades from the lower digit's tc.
module modn_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = DEC_MOD
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // Largest legal count; with MODULUS == 2**WIDTH this is all ones and the
    // load clamp can never trigger, so wrap is simply the natural overflow.
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    // Reject moduli that cannot be represented or that make no sense as a counter.
    if (MODULUS < 2 || (64'd1 << WIDTH) < 64'(MODULUS)) begin : g_bad_params
        $error("modn_updown_counter: need 2 <= MODULUS <= 2**WIDTH");
    end

    // Count register and wrap pulse: clear > load > count > hold.
    always_ff @(posedge clk) begin
        if (!clr) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            // Clamp out-of-range loads so q never leaves 0..MODULUS-1.
            q    <= (din > Q_MAX) ? Q_MAX : din;
            wrap <= 1'b0;
        end else if (en) begin
            if (up) begin
                if (q == Q_MAX) begin
                    q    <= '0;
                    wrap <= 1'b1;
                end else begin
                    q    <= q + WIDTH'(1);
                    wrap <= 1'b0;
                end
            end else begin
                if (q == '0) begin
                    q    <= Q_MAX;
                    wrap <= 1'b1;
                end else begin
                    q    <= q - WIDTH'(1);
                    wrap <= 1'b0;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    // Terminal count is combinational so the next digit advances on the same edge.
    assign tc = en & (up ? (q == Q_MAX) : (q == '0));

endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed self-checking bench for modn_updown_counter: mod-10 cell, two-digit
// decimal cascade and a mod-60 cell on 6 bits.
// Inputs are driven 1 time unit after posedge and outputs sampled there too.
module tb_modn_updown_counter;

    logic       clk;
    logic       clr;

    // Single mod-10 cell.
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic [3:0] q;
    logic       tc;
    logic       wrap;

    // Two-digit decimal cascade.
    logic       cen;
    logic [3:0] q0;
    logic [3:0] q1;
    logic       tc0;
    logic       tc1;
    logic       wrap0;
    logic       wrap1;
    logic       en1;

    // Mod-60 cell.
    logic       en60;
    logic [5:0] q60;
    logic       tc60;
    logic       wrap60;

    int checks;
    int errors;

    assign en1 = tc0 & cen;

    modn_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .din(din),
        .q(q), .tc(tc), .wrap(wrap)
    );

    modn_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dig0 (
        .clk(clk), .clr(clr), .en(cen), .up(1'b1), .load(1'b0), .din(4'd0),
        .q(q0), .tc(tc0), .wrap(wrap0)
    );

    modn_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dig1 (
        .clk(clk), .clr(clr), .en(en1), .up(1'b1), .load(1'b0), .din(4'd0),
        .q(q1), .tc(tc1), .wrap(wrap1)
    );

    modn_updown_counter #(.WIDTH(6), .MODULUS(60)) u_mod60 (
        .clk(clk), .clr(clr), .en(en60), .up(1'b1), .load(1'b0), .din(6'd0),
        .q(q60), .tc(tc60), .wrap(wrap60)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr  = 1'b0;
        en   = 1'b0;
        up   = 1'b1;
        load = 1'b0;
        din  = 4'd0;
        cen  = 1'b0;
        en60 = 1'b0;

        // Reset for two edges.
        tick();
        tick();
        chk("rst_q", 32'(q), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_tc", 32'(tc), 0);
        chk("rst_q0", 32'(q0), 0);
        chk("rst_q1", 32'(q1), 0);
        chk("rst_q60", 32'(q60), 0);

        // Up count 0..9,0.
        clr = 1'b1;
        en  = 1'b1;
        up  = 1'b1;
        chk("up_tc_at0", 32'(tc), 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("up_q", 32'(q), 32'(i % 10));
            chk("up_wrap", 32'(wrap), (i == 10) ? 1 : 0);
            chk("up_tc", 32'(tc), ((i % 10) == 9) ? 1 : 0);
        end

        // Down count from 0: 9,8,...,0,9.
        up = 1'b0;
        #1;
        chk("dn_tc_at0", 32'(tc), 1);
        for (int i = 0; i <= 10; i++) begin
            tick();
            chk("dn_q", 32'(q), (i == 10) ? 9 : 32'(9 - i));
            chk("dn_wrap", 32'(wrap), (i == 0 || i == 10) ? 1 : 0);
            chk("dn_tc", 32'(tc), (i == 9) ? 1 : 0);
        end

        // Load 7 with counting disabled.
        en   = 1'b0;
        up   = 1'b1;
        load = 1'b1;
        din  = 4'd7;
        tick();
        chk("ld_q7", 32'(q), 7);
        chk("ld_wrap", 32'(wrap), 0);

        // Out-of-range load clamps to 9, and load beats en.
        en  = 1'b1;
        din = 4'd12;
        tick();
        chk("ld_clamp", 32'(q), 9);
        chk("ld_clamp_wrap", 32'(wrap), 0);

        // Hold at 9 for 5 cycles; tc stays low while en is low.
        load = 1'b0;
        en   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_q", 32'(q), 9);
            chk("hold_tc", 32'(tc), 0);
            chk("hold_wrap", 32'(wrap), 0);
        end

        // Load 5, count to 6, then clear together with load of 3.
        load = 1'b1;
        din  = 4'd5;
        tick();
        load = 1'b0;
        en   = 1'b1;
        tick();
        chk("pre_rst_q", 32'(q), 6);
        clr  = 1'b0;
        load = 1'b1;
        din  = 4'd3;
        tick();
        chk("rstpri_q", 32'(q), 0);
        chk("rstpri_wrap", 32'(wrap), 0);

        // Clear at 9 while counting up must suppress the wrap pulse.
        clr  = 1'b1;
        load = 1'b1;
        din  = 4'd9;
        tick();
        chk("ld9_q", 32'(q), 9);
        load = 1'b0;
        clr  = 1'b0;
        tick();
        chk("rst9_q", 32'(q), 0);
        chk("rst9_wrap", 32'(wrap), 0);

        // Release clear; counting resumes from 0.
        clr = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("resume_q", 32'(q), 32'(i));
        end
        en = 1'b0;

        // Two-digit cascade: 100 enabled cycles step 00..99 then back to 00.
        cen = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            chk("cas_q0", 32'(q0), 32'(i % 10));
            chk("cas_q1", 32'(q1), 32'((i / 10) % 10));
            chk("cas_wrap1", 32'(wrap1), (i == 100) ? 1 : 0);
        end
        cen = 1'b0;

        // Mod-60 on 6 bits: 0..59 then 0, never 60..63.
        en60 = 1'b1;
        for (int i = 1; i <= 61; i++) begin
            tick();
            chk("m60_q", 32'(q60), 32'(i % 60));
            chk("m60_wrap", 32'(wrap60), (i == 60) ? 1 : 0);
            chk("m60_range", 32'(q60 < 6'd60), 1);
        end
        en60 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modn_updown_counter.md
Name: modn_updown_counter

Overview:
Synchronous, parametrised modulo-N counter; next generation of our ripple decade counter.
- Single clock; no derived clocks and no async clear-by-compare glitch.
- Adds: any modulus, up/down direction, parallel load, count enable, cascade terminal-count output, registered wrap pulse.
- Used as the digit cell for multi-digit BCD/time counters and as a general event/tick divider.

Parameters:
WIDTH, 4, counter width in bits; must satisfy 2**WIDTH >= MODULUS.
MODULUS, 10, count range 0..MODULUS-1; legal range 2..2**WIDTH.

Ports:
clk  input  1  clock; all state updates on posedge clk.
clr  input  1  reset, synchronous, active-low; clr==0 at a posedge clears state.
en  input  1  count enable; also the cascade input, driven by the lower digit's tc.
up  input  1  direction: 1 counts up, 0 counts down.
load  input  1  parallel load strobe.
din  input  WIDTH  parallel load value.
q  output  WIDTH  current count, registered.
tc  output  1  terminal count, combinational: en & (up ? q==MODULUS-1 : q==0).
wrap  output  1  registered one-cycle pulse; asserted the cycle after q wrapped.

Behaviour:
- Reset: clr==0 at posedge clk -> q=0, wrap=0. Reset has priority over every other input, including load and en.
- Reset mid-count: the next edge with clr==0 forces q=0 regardless of state. With clr==1 and en==1 on the following edge, counting resumes from 0.
- Priority when clr==1: load > en > hold.
- Load (load==1):
  - din <= MODULUS-1 -> q<=din.
  - din > MODULUS-1 -> q<=MODULUS-1 (saturating clamp; q never leaves the legal range).
  - wrap<=0. Load ignores en.
- Count up (en==1, up==1): q==MODULUS-1 -> q<=0 and wrap<=1; otherwise q<=q+1 and wrap<=0.
- Count down (en==1, up==0): q==0 -> q<=MODULUS-1 and wrap<=1; otherwise q<=q-1 and wrap<=0.
- Hold (en==0, load==0): q unchanged; wrap<=0.
- Latency:
  - q updates one clock after the qualifying edge.
  - tc is combinational from q, en and up, with zero latency. This lets cascaded stages advance on the same edge as the lower stage's wrap.
  - wrap is valid one cycle after the wrap edge and lasts exactly one cycle.
- Direction change (up toggling between edges) takes effect on the next edge. No state is kept about the previous direction.
- MODULUS == 2**WIDTH: wrap is natural overflow; behaviour otherwise identical.
- Cascade rule: stage k.en = stage k-1.tc & global_en. All stages share clk and clr. No ripple clocking is permitted.
- No internal state other than q and wrap. No FSM beyond the count register itself.
- Elaboration check: fail on MODULUS<2 or 2**WIDTH<MODULUS.

Decomposition:
- Shared package counter_pkg:
  - localparam defaults DEC_MOD=10, HEX_MOD=16, SEC_MOD=60.
  - function clog2 for width derivation by instantiators.
- No sub-module inside this block.
- A separate wrapper, modn_cascade (DIGITS parameter), is the natural next consumer; it is out of scope here.

Test Plan:
- Up count, mod 10: clr=0 for 2 edges, then clr=1, en=1, up=1 -> q sequence 0,1,...,9,0. tc=1 only while q==9. wrap=1 only in the cycle after 9->0.
- Down count, mod 10: clr=1, en=1, up=0, starting from q=0 -> q sequence 9,8,...,0,9. tc=1 while q==0. wrap pulses after 0->9.
- Load and clamp:
  - load=1, din=7 -> q=7 next cycle.
  - load=1, din=12 -> q=9.
  - load=1 with en=1 -> load wins.
  - en=0 afterwards -> q holds 9 for 5 cycles.
- Reset priority: mid-count at q=6, drive clr=0 together with load=1, din=3 -> q=0 and wrap=0. Release clr -> count resumes 1,2,...
- Cascade: two instances with MODULUS=10, stage1.en=stage0.tc, 100 enabled cycles -> {q1,q0} steps 00..99 then 00. Stage1 advances on the same edge that stage0 goes 9->0.
- Non-decimal modulus: WIDTH=6, MODULUS=60, up count -> q 0..59 then 0. q never reaches 60..63.
